// File: rtl/serial_pkg.sv
// Shared types for the serial framing blocks.
// Frame FSM states and line levels.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/word_fifo2.sv
// Two-entry word buffer, head always visible.
// Head holds its last value once drained.
module word_fifo2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] e0_q, e1_q;
  logic [1:0]       n_q;
  logic             do_pop, do_push;

  assign full    = (n_q == 2'd2);
  assign empty   = (n_q == 2'd0);
  assign head    = e0_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Entry and occupancy update; a pop frees room for a same-cycle push.
  always_ff @(posedge clk) begin
    if (!reset) begin
      e0_q <= '0;
      e1_q <= '0;
      n_q  <= 2'd0;
    end else begin
      unique case (n_q)
        2'd0: begin
          if (do_push) begin
            e0_q <= push_data;
            n_q  <= 2'd1;
          end
        end
        2'd1: begin
          unique case ({do_push, do_pop})
            2'b11: e0_q <= push_data;
            2'b10: begin
              e1_q <= push_data;
              n_q  <= 2'd2;
            end
            2'b01: n_q <= 2'd0;
            default: ;
          endcase
        end
        2'd2: begin
          if (do_pop) begin
            e0_q <= e1_q;
            if (do_push) e1_q <= push_data;
            else n_q <= 2'd1;
          end
        end
        default: n_q <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/serial_frame_deserializer.sv
// Rebuilds framed parallel words from a strobed serial bit stream.
// Start bit, LSB-first data, optional even parity, stop bit.
module serial_frame_deserializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             par_q, par_d;
  logic             pmis_q, pmis_d;
  logic             ferr_q, ferr_d;
  logic             perr_q, perr_d;
  logic             ovf_q, ovf_d;
  logic             push, pop, full, empty;
  logic [WIDTH-1:0] head;

  // Frame state register; only strobed bits move it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      pmis_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      pmis_q  <= pmis_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state, shift/parity datapath and stop-bit verdict.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    pmis_d  = pmis_q;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    push    = 1'b0;
    if (bit_valid) begin
      unique case (state_q)
        IDLE: begin
          if (bit_in == START_LEVEL) begin
            state_d = DATA;
            cnt_d   = '0;
            sh_d    = '0;
            par_d   = 1'b0;
            pmis_d  = 1'b0;
          end
        end
        DATA: begin
          sh_d  = sh_q | (WIDTH'(bit_in) << cnt_q);
          par_d = par_q ^ bit_in;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1))
            state_d = PARITY_EN ? PARITY : STOP;
        end
        PARITY: begin
          pmis_d  = (bit_in != par_q);
          state_d = STOP;
        end
        STOP: begin
          ferr_d  = (bit_in != IDLE_LEVEL);
          perr_d  = pmis_q;
          push    = (bit_in == IDLE_LEVEL) & ~pmis_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign pop   = ~empty & out_ready;
  assign ovf_d = ovf_q | (push & full & ~pop);

  word_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(sh_q),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );

  assign data_out   = head;
  assign out_valid  = ~empty;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Bench for serial_frame_deserializer (WIDTH=4, parity on).
// Frame-level reference model plus directed literal checks.
module tb_serial_frame_deserializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         bit_in;
  logic         bit_valid;
  logic [W-1:0] data_out;
  logic         out_valid;
  logic         out_ready;
  logic         frame_err;
  logic         parity_err;
  logic         overflow;

  serial_frame_deserializer #(.WIDTH(W), .PARITY_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // what the driver is doing on the current strobe
  bit           s_stop = 0;
  bit           s_ok   = 0;
  bit           s_fe   = 0;
  bit           s_pe   = 0;
  logic [W-1:0] s_data = '0;
  int           gapmode = 0;
  bit           rnd_ready = 0;

  // reference model state
  logic [W-1:0] mq[$];
  logic [W-1:0] m_last = '0;
  bit           m_fe = 0, m_pe = 0, m_ov = 0;
  bit           m_pop;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Word-level model: buffer of up to two good frames.
  always @(posedge clk) begin
    if (!reset) begin
      mq.delete();
      m_last = '0;
      m_fe = 0;
      m_pe = 0;
      m_ov = 0;
    end else begin
      m_pop = (mq.size() > 0) && out_ready;
      if (m_pop) void'(mq.pop_front());
      m_fe = s_stop && s_fe;
      m_pe = s_stop && s_pe;
      if (s_stop && s_ok) begin
        if (mq.size() < 2) mq.push_back(s_data);
        else m_ov = 1;
      end
      if (mq.size() > 0) m_last = mq[0];
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 16'(out_valid), 16'(mq.size() > 0));
      chk("data_out", 16'(data_out), 16'(m_last));
      chk("frame_err", 16'(frame_err), 16'(m_fe));
      chk("parity_err", 16'(parity_err), 16'(m_pe));
      chk("overflow", 16'(overflow), 16'(m_ov));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      bit_valid = 1'($urandom_range(0, 1));
      bit_in    = 1'b1;
      tick();
      bit_valid = 1'b0;
    end
  endtask

  task automatic send_bit(input logic b, input bit stop, input bit ok,
                          input bit fe, input bit pe);
    int gaps;
    gaps = (gapmode == 1) ? 2 : (gapmode == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (gaps) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      bit_valid = 1'b0;
      bit_in    = 1'($urandom_range(0, 1));
      tick();
    end
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    bit_valid = 1'b1;
    bit_in    = b;
    s_stop    = stop;
    s_ok      = ok;
    s_fe      = fe;
    s_pe      = pe;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b1;
    s_stop    = 0;
    s_ok      = 0;
    s_fe      = 0;
    s_pe      = 0;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input bit flip,
                            input logic stopb);
    logic p;
    p = (^d) ^ flip;
    send_bit(1'b0, 0, 0, 0, 0);
    for (int i = 0; i < W; i++) send_bit(d[i], 0, 0, 0, 0);
    send_bit(p, 0, 0, 0, 0);
    s_data = d;
    send_bit(stopb, 1, stopb && !flip, !stopb, flip);
  endtask

  initial begin
    reset     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b1;
    out_ready = 1'b0;
    tick();
    chk_en = 1'b1;
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_data_out", 16'(data_out), 16'd0);
    chk("rst_overflow", 16'(overflow), 16'd0);
    tick();
    reset = 1'b1;
    tick();

    // good frame 4'hD
    out_ready = 1'b1;
    send_frame(4'hD, 0, 1'b1);
    chk("d_valid", 16'(out_valid), 16'd1);
    chk("d_data", 16'(data_out), 16'hD);
    chk("d_perr", 16'(parity_err), 16'd0);
    idle(3);

    // parity flipped
    send_frame(4'hD, 1, 1'b1);
    chk("p_perr", 16'(parity_err), 16'd1);
    chk("p_valid", 16'(out_valid), 16'd0);
    tick();
    chk("p_perr_one", 16'(parity_err), 16'd0);

    // bad stop bit, then recovery
    send_frame(4'h7, 0, 1'b0);
    chk("f_ferr", 16'(frame_err), 16'd1);
    chk("f_valid", 16'(out_valid), 16'd0);
    idle(2);
    send_frame(4'h3, 0, 1'b1);
    chk("f_next", 16'(data_out), 16'h3);
    chk("f_next_v", 16'(out_valid), 16'd1);
    idle(3);

    // overflow
    out_ready = 1'b0;
    send_frame(4'h1, 0, 1'b1);
    send_frame(4'h2, 0, 1'b1);
    send_frame(4'h3, 0, 1'b1);
    chk("o_ovf", 16'(overflow), 16'd1);
    chk("o_head", 16'(data_out), 16'h1);
    out_ready = 1'b1;
    tick();
    chk("o_head2", 16'(data_out), 16'h2);
    tick();
    chk("o_empty", 16'(out_valid), 16'd0);
    idle(4);
    chk("o_sticky", 16'(overflow), 16'd1);

    // sparse strobes
    gapmode = 1;
    send_frame(4'hA, 0, 1'b1);
    chk("g_data", 16'(data_out), 16'hA);
    chk("g_valid", 16'(out_valid), 16'd1);
    gapmode = 0;
    idle(3);

    // reset mid-frame
    send_bit(1'b0, 0, 0, 0, 0);
    send_bit(1'b1, 0, 0, 0, 0);
    send_bit(1'b1, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    chk("r_valid", 16'(out_valid), 16'd0);
    chk("r_data", 16'(data_out), 16'd0);
    chk("r_ovf", 16'(overflow), 16'd0);
    tick();
    reset = 1'b1;
    idle(2);
    send_frame(4'h5, 0, 1'b1);
    chk("r_data5", 16'(data_out), 16'h5);
    chk("r_valid5", 16'(out_valid), 16'd1);
    idle(3);

    // randomized frames, random gaps and back-pressure
    gapmode   = 2;
    rnd_ready = 1;
    for (int k = 0; k < 80; k++) begin
      logic [W-1:0] d;
      bit           fl;
      logic         sb;
      d  = W'($urandom_range(0, 15));
      fl = ($urandom_range(0, 4) == 0);
      sb = ($urandom_range(0, 5) != 0);
      send_frame(d, fl, sb);
      idle(int'($urandom_range(0, 2)));
    end
    rnd_ready = 0;
    out_ready = 1'b1;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
